// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access stage: FSM states, exception codes, access sizes.
// The MEM_ACCESS_TRACE_EN macro adds the trace verbosity filter shared with the other stages.
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0] EXC_NONE   = 2'b00;
    localparam logic [1:0] EXC_LD_MIS = 2'b01;
    localparam logic [1:0] EXC_ST_MIS = 2'b10;
    localparam logic [1:0] EXC_TMO    = 2'b11;

    // funct3[1:0] selects the size; funct3[2] selects zero-extension
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

`ifdef MEM_ACCESS_TRACE_EN
    localparam int TRACE_VERBOSITY = 1;

    function automatic bit trace_enabled(input int level);
        return level <= TRACE_VERBOSITY;
    endfunction
`endif

endpackage

// File: rtl/mem_access_align.sv
// Combinational lane logic: store strobe/data placement, load extraction with sign/zero
// extension, and natural-alignment check for the selected access size.
module mem_align
    import mem_access_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] addr_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [7:0]      wstrb_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] ldata_o,
    output logic            misaligned_o
);

    logic [2:0]      off;
    logic [5:0]      sh;
    logic [XLEN-1:0] shifted;

    assign off     = addr_i[2:0];
    assign sh      = {off, 3'b000};
    assign wstrb_o = size_mask(funct3_i[1:0]) << off;
    assign wdata_o = wdata_i << sh;
    assign shifted = rdata_i >> sh;

    always_comb begin
        ldata_o      = shifted;
        misaligned_o = 1'b0;
        case (funct3_i[1:0])
            SZ_B: begin
                ldata_o = funct3_i[2] ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                      : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                ldata_o      = funct3_i[2] ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                           : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
                misaligned_o = off[0];
            end
            SZ_W: begin
                ldata_o      = funct3_i[2] ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                           : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
                misaligned_o = |off[1:0];
            end
            default: begin
                misaligned_o = |off;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: one data-bus transaction per load/store, registered writeback packet.
// Define MEM_ACCESS_TRACE_EN to print a trace line on every writeback.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int TIMEOUT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_data2,
    input  logic            in_load_op,
    input  logic            in_store_op,
    input  logic [2:0]      in_funct3,
    output logic            stall,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [7:0]      bus_wstrb,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_rdata,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_pc,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [1:0]      wb_exc
);

    state_e               state_q, state_d;
    logic [XLEN-1:0]      pc_q, pc_d, addr_q, addr_d, data_q, data_d;
    logic [4:0]           rd_q, rd_d;
    logic [2:0]           funct3_q, funct3_d;
    logic                 store_q, store_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]      wb_pc_q, wb_pc_d, wb_data_q, wb_data_d;
    logic [4:0]           wb_rd_q, wb_rd_d;
    logic [1:0]           wb_exc_q, wb_exc_d;

    logic            idle, is_mem, start, done, mis;
    logic [XLEN-1:0] al_addr, al_wdata, al_ldata;
    logic [2:0]      al_funct3;
    logic [7:0]      al_wstrb;

    // In IDLE the aligner checks the incoming op; while busy it serves the captured one.
    assign idle      = (state_q == ST_IDLE);
    assign al_addr   = idle ? in_result : addr_q;
    assign al_funct3 = idle ? in_funct3 : funct3_q;
    assign is_mem    = in_load_op | in_store_op;

    mem_align #(.XLEN(XLEN)) u_align (
        .addr_i       (al_addr),
        .funct3_i     (al_funct3),
        .wdata_i      (data_q),
        .rdata_i      (bus_rdata),
        .wstrb_o      (al_wstrb),
        .wdata_o      (al_wdata),
        .ldata_o      (al_ldata),
        .misaligned_o (mis)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        data_d     = data_q;
        funct3_d   = funct3_q;
        store_d    = store_q;
        tmo_d      = tmo_q;
        wb_valid_d = 1'b0;
        wb_pc_d    = wb_pc_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_exc_d   = wb_exc_q;
        start      = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_pc_d    = in_pc;
                        wb_rd_d    = in_rd;
                        wb_data_d  = in_result;
                        wb_exc_d   = EXC_NONE;
                    end else if (mis) begin
                        wb_valid_d = 1'b1;
                        wb_pc_d    = in_pc;
                        wb_rd_d    = 5'd0;
                        wb_data_d  = in_result;
                        wb_exc_d   = in_store_op ? EXC_ST_MIS : EXC_LD_MIS;
                    end else begin
                        start    = 1'b1;
                        state_d  = ST_REQ;
                        tmo_d    = '0;
                        pc_d     = in_pc;
                        rd_d     = in_rd;
                        addr_d   = in_result;
                        data_d   = in_data2;
                        funct3_d = in_funct3;
                        store_d  = in_store_op;
                    end
                end
            end
            ST_REQ, ST_RESP: begin
                if ((state_q == ST_REQ) && bus_gnt && !store_q && !bus_rvalid) begin
                    state_d = ST_RESP;
                    tmo_d   = '0;
                end else if ((state_q == ST_REQ) ? bus_gnt : bus_rvalid) begin
                    done       = 1'b1;
                    state_d    = ST_IDLE;
                    tmo_d      = '0;
                    wb_valid_d = 1'b1;
                    wb_pc_d    = pc_q;
                    wb_rd_d    = store_q ? 5'd0 : rd_q;
                    wb_data_d  = store_q ? '0 : al_ldata;
                    wb_exc_d   = EXC_NONE;
                end else if (tmo_q == {TIMEOUT_W{1'b1}}) begin
                    done       = 1'b1;
                    state_d    = ST_IDLE;
                    tmo_d      = '0;
                    wb_valid_d = 1'b1;
                    wb_pc_d    = pc_q;
                    wb_rd_d    = 5'd0;
                    wb_data_d  = addr_q;
                    wb_exc_d   = EXC_TMO;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stall drops in the completion cycle so execute can advance as the writeback fires.
    assign stall     = !rst && ((!idle && !done) || start);
    assign bus_req   = (state_q == ST_REQ);
    assign bus_we    = bus_req && store_q;
    assign bus_addr  = bus_req ? {addr_q[XLEN-1:3], 3'b000} : '0;
    assign bus_wdata = bus_req ? al_wdata : '0;
    assign bus_wstrb = bus_req ? al_wstrb : 8'h00;

    assign wb_valid = wb_valid_q;
    assign wb_pc    = wb_pc_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign wb_exc   = wb_exc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            rd_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            funct3_q   <= '0;
            store_q    <= 1'b0;
            tmo_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_pc_q    <= '0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_exc_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            funct3_q   <= funct3_d;
            store_q    <= store_d;
            tmo_q      <= tmo_d;
            wb_valid_q <= wb_valid_d;
            wb_pc_q    <= wb_pc_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_exc_q   <= wb_exc_d;
        end
    end

`ifdef MEM_ACCESS_TRACE_EN
    always_ff @(posedge clk) begin
        if (wb_valid_q && trace_enabled(1)) begin
            $display("%0t mem_access pc=%h rd=%0d data=%h addr=%h wstrb=%h exc=%b", $time,
                     wb_pc_q, wb_rd_q, wb_data_q, addr_q,
                     size_mask(funct3_q[1:0]) << addr_q[2:0], wb_exc_q);
        end
    end
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU pass-through, stores, loads, misalignment, timeout, reset.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] in_pc = '0, in_result = '0, in_data2 = '0, bus_rdata = '0;
    logic [4:0]  in_rd = '0;
    logic        in_load_op = 1'b0, in_store_op = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
    logic        stall, bus_req, bus_we, wb_valid;
    logic [63:0] bus_addr, bus_wdata, wb_pc, wb_data;
    logic [7:0]  bus_wstrb;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_exc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_rd(in_rd),
        .in_result(in_result), .in_data2(in_data2), .in_load_op(in_load_op),
        .in_store_op(in_store_op), .in_funct3(in_funct3), .stall(stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_exc(wb_exc)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic present(input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] res,
                           input logic [63:0] d2, input logic ld, input logic st,
                           input logic [2:0] f3);
        in_valid = 1'b1; in_pc = pc; in_rd = rd; in_result = res; in_data2 = d2;
        in_load_op = ld; in_store_op = st; in_funct3 = f3;
    endtask

    task automatic drop();
        in_valid = 1'b0; in_load_op = 1'b0; in_store_op = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [63:0] addr, input logic [2:0] f3,
                            input logic [63:0] d2, input logic also_ld,
                            input logic [7:0] exp_strb, input logic [63:0] exp_wdata);
        tick(); present(64'h400 + addr, 5'd3, addr, d2, also_ld, 1'b1, f3); #1;
        chk({tag, "_stall_issue"}, stall, 1);
        chk({tag, "_noreq_issue"}, bus_req, 0);
        tick(); bus_gnt = 1'b1; #1;
        chk({tag, "_req"}, bus_req, 1);
        chk({tag, "_we"}, bus_we, 1);
        chk({tag, "_addr"}, bus_addr, {addr[63:3], 3'b000});
        chk({tag, "_wstrb"}, bus_wstrb, exp_strb);
        chk({tag, "_wdata"}, bus_wdata, exp_wdata);
        chk({tag, "_stall_done"}, stall, 0);
        tick(); bus_gnt = 1'b0; drop(); #1;
        chk({tag, "_wbv"}, wb_valid, 1);
        chk({tag, "_wbrd"}, wb_rd, 0);
        chk({tag, "_wbexc"}, wb_exc, 0);
        chk({tag, "_wbpc"}, wb_pc, 64'h400 + addr);
    endtask

    // delay = cycles from grant to rvalid (0 = same cycle as grant)
    task automatic do_load(input string tag, input logic [63:0] addr, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [63:0] rdata, input int delay,
                           input logic [63:0] exp_data);
        tick(); present(64'h800 + addr, rd, addr, 64'h0, 1'b1, 1'b0, f3); #1;
        chk({tag, "_stall_issue"}, stall, 1);
        tick(); bus_gnt = 1'b1;
        if (delay == 0) begin bus_rvalid = 1'b1; bus_rdata = rdata; end
        #1;
        chk({tag, "_req"}, bus_req, 1);
        chk({tag, "_we"}, bus_we, 0);
        chk({tag, "_addr"}, bus_addr, {addr[63:3], 3'b000});
        chk({tag, "_stall_gnt"}, stall, (delay == 0) ? 1'b0 : 1'b1);
        for (int d = 1; d <= delay; d++) begin
            tick(); bus_gnt = 1'b0;
            if (d == delay) begin bus_rvalid = 1'b1; bus_rdata = rdata; end
            #1;
            chk({tag, "_resp_noreq"}, bus_req, 0);
            chk({tag, "_stall_resp"}, stall, (d == delay) ? 1'b0 : 1'b1);
        end
        tick(); bus_gnt = 1'b0; bus_rvalid = 1'b0; drop(); #1;
        chk({tag, "_wbv"}, wb_valid, 1);
        chk({tag, "_wbrd"}, wb_rd, rd);
        chk({tag, "_wbdata"}, wb_data, exp_data);
        chk({tag, "_wbexc"}, wb_exc, 0);
        chk({tag, "_stall_wb"}, stall, 0);
    endtask

    task automatic do_misaligned(input string tag, input logic [63:0] addr, input logic [2:0] f3,
                                 input logic st, input logic [1:0] exp_exc);
        tick(); present(64'hC00, 5'd12, addr, 64'hFFFF, ~st, st, f3); #1;
        chk({tag, "_nostall"}, stall, 0);
        chk({tag, "_noreq"}, bus_req, 0);
        tick(); drop(); #1;
        chk({tag, "_noreq2"}, bus_req, 0);
        chk({tag, "_wbv"}, wb_valid, 1);
        chk({tag, "_wbexc"}, wb_exc, exp_exc);
        chk({tag, "_wbdata"}, wb_data, addr);
        chk({tag, "_wbrd"}, wb_rd, 0);
    endtask

    initial begin
        int  n;
        bit  got;
        logic prev_stall;

        #2;
        chk("rst_wbv", wb_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_wbdata", wb_data, 0);
        chk("rst_addr", bus_addr, 0);
        tick(); tick(); rst = 1'b0;

        // ALU pass-through
        tick(); present(64'h100, 5'd5, 64'h1234, 64'h0, 1'b0, 1'b0, 3'b000); #1;
        chk("alu_stall0", stall, 0);
        tick(); drop(); #1;
        chk("alu_wbv", wb_valid, 1);
        chk("alu_wbrd", wb_rd, 5);
        chk("alu_wbdata", wb_data, 64'h1234);
        chk("alu_wbexc", wb_exc, 0);
        chk("alu_wbpc", wb_pc, 64'h100);
        chk("alu_stall1", stall, 0);
        tick(); #1;
        chk("alu_pulse", wb_valid, 0);

        do_store("sb", 64'h1003, 3'b000, 64'hAB, 1'b0, 8'h08, 64'h0000_0000_AB00_0000);
        do_store("sw_both", 64'h1004, 3'b010, 64'h1122_3344, 1'b1, 8'hF0, 64'h1122_3344_0000_0000);
        do_store("sd", 64'h1008, 3'b011, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 8'hFF,
                 64'hDEAD_BEEF_0BAD_F00D);

        do_load("lh", 64'h2002, 3'b001, 5'd7, 64'h0000_0000_8001_0000, 2, 64'hFFFF_FFFF_FFFF_8001);
        do_load("lhu", 64'h2002, 3'b101, 5'd7, 64'h0000_0000_8001_0000, 2, 64'h0000_0000_0000_8001);
        do_load("lb", 64'h4007, 3'b000, 5'd8, 64'h8000_0000_0000_0000, 0, 64'hFFFF_FFFF_FFFF_FF80);
        do_load("lwu", 64'h4004, 3'b110, 5'd9, 64'hF234_5678_0000_0000, 1, 64'h0000_0000_F234_5678);
        do_load("lw", 64'h4004, 3'b010, 5'd9, 64'hF234_5678_0000_0000, 1, 64'hFFFF_FFFF_F234_5678);
        do_load("ld111", 64'h4008, 3'b111, 5'd10, 64'h0123_4567_89AB_CDEF, 0, 64'h0123_4567_89AB_CDEF);

        do_misaligned("lw_mis", 64'h3002, 3'b010, 1'b0, 2'b01);
        do_misaligned("sh_mis", 64'h3001, 3'b001, 1'b1, 2'b10);
        do_misaligned("ld_mis", 64'h3004, 3'b011, 1'b0, 2'b01);

        // Timeout with grant held low; execute holds the instruction while stalled
        tick(); present(64'h500, 5'd11, 64'h5000, 64'h0, 1'b1, 1'b0, 3'b011); #1;
        prev_stall = stall;
        got = 0; n = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!prev_stall) drop();
            #1;
            if (wb_valid) begin
                got = 1; n = i + 1;
                break;
            end
            prev_stall = stall;
        end
        chk("tmo_seen", got, 1);
        chk("tmo_window", (n >= 255 && n <= 258), 1);
        chk("tmo_exc", wb_exc, 2'b11);
        chk("tmo_wbrd", wb_rd, 0);
        chk("tmo_stall", stall, 0);
        drop();
        tick(); bus_rvalid = 1'b1; bus_rdata = 64'h5555; #1;
        chk("late_rv_stall", stall, 0);
        tick(); bus_rvalid = 1'b0; #1;
        chk("late_rv_wbv", wb_valid, 0);
        chk("late_rv_req", bus_req, 0);

        // Reset asserted while waiting for a response
        tick(); present(64'h600, 5'd9, 64'h6000, 64'h0, 1'b1, 1'b0, 3'b011); #1;
        tick(); bus_gnt = 1'b1; #1;
        chk("rr_req", bus_req, 1);
        tick(); bus_gnt = 1'b0; #1;
        chk("rr_resp_stall", stall, 1);
        chk("rr_resp_noreq", bus_req, 0);
        #1; rst = 1'b1; drop(); #1;
        chk("rr_stall", stall, 0);
        chk("rr_req0", bus_req, 0);
        chk("rr_wbv", wb_valid, 0);
        tick(); rst = 1'b0; #1;
        chk("rr_wbv_after", wb_valid, 0);
        do_load("post_rst", 64'h6008, 3'b011, 5'd9, 64'h0123_4567_89AB_CDEF, 1,
                64'h0123_4567_89AB_CDEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Pipeline stage directly downstream of execute.
- Consumes the execute result (effective address or ALU value), store data, destination register and load/store ops.
- Performs at most one 64-bit data-bus transaction per instruction and presents a registered writeback packet to the writeback stage.
- Back-pressures execute through `stall` while a memory transaction is outstanding.

Parameters:
- XLEN, 64, datapath and address width
- TIMEOUT_W, 8, width of bus-response timeout counter (timeout = 2**TIMEOUT_W-1 cycles)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  execute presents an instruction this cycle
- in_pc  in  XLEN  instruction pc
- in_rd  in  5  destination register index
- in_result  in  XLEN  ALU result / effective address
- in_data2  in  XLEN  store data
- in_load_op  in  1  instruction is a load
- in_store_op  in  1  instruction is a store
- in_funct3  in  3  access size/sign (000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu)
- stall  out  1  execute must hold its outputs
- bus_req  out  1  data-bus request valid
- bus_we  out  1  1 = write
- bus_addr  out  XLEN  8-byte-aligned address ({addr[XLEN-1:3],3'b0})
- bus_wdata  out  XLEN  store data shifted into lane
- bus_wstrb  out  8  byte enables
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  read data valid / write ack
- bus_rdata  in  XLEN  read data
- wb_valid  out  1  writeback packet valid (one-cycle pulse)
- wb_pc  out  XLEN  pc of completed instruction
- wb_rd  out  5  destination (0 for stores)
- wb_data  out  XLEN  value to write back
- wb_exc  out  2  00 none, 01 load misaligned, 10 store misaligned, 11 bus timeout

Behaviour:
- Reset: all outputs 0; FSM = IDLE; captured fields and timeout counter cleared. Reset mid-transaction aborts it and drops any pending writeback.
- FSM states: IDLE, REQ, RESP.
- IDLE, non-memory op:
  - in_valid with neither op set → next cycle wb_valid=1, wb_data=in_result, wb_exc=0.
  - Latency 1; no stall.
- IDLE, misaligned memory op:
  - Misaligned: h with addr[0]≠0; w with addr[1:0]≠0; d with addr[2:0]≠0.
  - No bus access; next cycle wb_valid=1, wb_rd=0, wb_data=in_result (faulting address), wb_exc=01 (load) or 10 (store).
- IDLE, aligned memory op:
  - Capture pc, rd, addr, data, funct3, op; go to REQ.
  - stall=1 combinationally in the same cycle.
- REQ:
  - bus_req=1; address/data/strobe stable until bus_gnt.
  - On gnt: store → complete. Load → RESP, or complete directly if bus_rvalid is also 1 in the same cycle.
- RESP:
  - bus_req=0; wait for bus_rvalid, then complete.
- Complete:
  - Next cycle wb_valid=1, FSM returns to IDLE.
  - stall deasserts in the completion cycle, so execute may present the next instruction the cycle wb_valid fires.
- stall = (state≠IDLE) | (state==IDLE & in_valid & aligned memory op).
- Store lanes:
  - wstrb = size mask (b=0x01, h=0x03, w=0x0F, d=0xFF) << addr[2:0].
  - wdata = data2 << (8*addr[2:0]).
- Load extract:
  - rdata >> (8*addr[2:0]), then sign-extend (b/h/w) or zero-extend (bu/hu/wu); d passes unchanged.
  - funct3=111 is treated as d.
- Timeout:
  - Counter runs in REQ and RESP, clears on every state entry.
  - On saturation, abort to IDLE, emit wb_valid with wb_exc=11 and wb_rd=0.
  - A late bus_rvalid arriving in IDLE is ignored.
- in_load_op and in_store_op both set: treated as store.
- in_valid=0: no state change in IDLE.

Optional Feature:
- MEM_ACCESS_TRACE_EN
- Defined: on every wb_valid, $display of $time, pc, rd, wb_data, addr, wstrb and exc, using the same verbose-filter function as the other stages.
- Undefined: no simulation-only code compiled; RTL otherwise identical.

Decomposition:
- Shared package: state enum (IDLE/REQ/RESP), wb_exc encodings, funct3 size codes, size-to-mask function.
- One natural sub-module: mem_align, purely combinational. Handles strobe/wdata generation, load extraction/extension and misalignment detection.

Test Plan:
- ALU op in_result=0x1234, rd=5 → next cycle wb_valid=1, wb_rd=5, wb_data=0x1234, stall never 1.
- sb addr=0x1003, data2=0xAB, gnt same cycle → bus_wstrb=0x08, bus_wdata=0xAB000000, bus_addr=0x1000; wb_valid one cycle later, wb_rd=0.
- lh addr=0x2002, gnt cycle 1, rvalid cycle 3 with rdata=0x0000_0000_8001_0000 → wb_data=0xFFFF_FFFF_FFFF_8001; stall high for cycles 0–2. The same access as lhu → 0x8001.
- lw addr=0x3002 → no bus_req, wb_exc=01, wb_data=0x3002.
- ld with bus_gnt held 0 → after 255 cycles wb_exc=11. A subsequent rvalid is ignored.
- Assert rst in RESP → bus_req=0, wb_valid=0, stall=0 immediately; a fresh load after release completes normally.
